// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port, fixed-latency memory between the instruction fetch
//   (IF) port and the data memory (DM) port of a pipelined MIPS core. Each
//   access goes IDLE -> ACCESS -> RESP. The captured read data is returned
//   with a 1-cycle ready pulse. Combinational stall outputs freeze the
//   requesting pipeline stage.
//
// Handshake (both ports):
//   The requester raises *_req with its address, write enable and write data
//   stable, and holds them until it sees *_ready = 1 for one cycle. *_rdata is
//   valid in that cycle and is held until the next load on the same port. A
//   request still high in the cycle after the ready pulse counts as a new
//   request. Nothing is taken from the port that does not own the memory
//   until the FSM is back in IDLE.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   if_req/if_addr       fetch request and address
//   if_rdata/if_ready    fetched instruction and completion pulse
//   dm_req/dm_we         data request, 1 = store, 0 = load
//   dm_addr/dm_wdata     data address and store data
//   dm_rdata/dm_ready    load data and completion pulse
//   stall_if/stall_dm    req & ~ready for each port
//   mem_en/mem_we        memory command strobe (1 cycle) and write enable
//   mem_addr/mem_wdata   registered memory address and write data
//   mem_rdata            memory read data, valid LATENCY cycles after mem_en
//   dbg_state            current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Configuration:
//   FAIR_ARB_EN  when defined, IF is granted after STARVE_LIMIT consecutive
//                DM grants made while IF was waiting. When undefined, DM
//                always has priority and no streak counter is built.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    // Parameter legality checked at elaboration time.
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: LATENCY must be in 0..15");
    end
    if (STARVE_LIMIT < 0 || STARVE_LIMIT > 255) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT must be in 0..255");
    end

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_owner_dm;
    logic              r_is_store;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_ready;
    logic              r_dm_ready;

    logic              w_idle;
    logic              w_grant_dm;
    logic              w_grant_if;

    assign w_idle = (r_state == ST_IDLE);

`ifdef FAIR_ARB_EN
    localparam logic [7:0] STREAK_MAX = 8'(STARVE_LIMIT);

    logic [7:0] r_streak;
    logic       w_force_if;

    // IF overrides DM priority once DM has won STARVE_LIMIT times in a row
    // while IF was waiting.
    assign w_force_if = if_req & (r_streak >= STREAK_MAX);
    assign w_grant_dm = w_idle & dm_req & ~w_force_if;
    assign w_grant_if = w_idle & if_req & (~dm_req | w_force_if);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (!if_req || w_grant_if) begin
            r_streak <= '0;
        end else if (w_grant_dm && r_streak != 8'hFF) begin
            r_streak <= r_streak + 8'd1;
        end
    end
`else
    // DM is the older instruction in the pipeline, so it always wins.
    assign w_grant_dm = w_idle & dm_req;
    assign w_grant_if = w_idle & if_req & ~dm_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_owner_dm  <= 1'b0;
            r_is_store  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dm || w_grant_if) begin
                        r_owner_dm <= w_grant_dm;
                        r_is_store <= w_grant_dm & dm_we;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_grant_dm & dm_we;
                        r_mem_addr <= w_grant_dm ? dm_addr : if_addr;
                        // Fetches never write, so the last store data is kept.
                        if (w_grant_dm) begin
                            r_mem_wdata <= dm_wdata;
                        end
                        r_cnt   <= LAT_CNT;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // The command is only presented in the first ACCESS cycle.
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        if (!r_owner_dm) begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end else begin
                            // A store leaves the previous load data in place.
                            if (!r_is_store) begin
                                r_dm_rdata <= mem_rdata;
                            end
                            r_dm_ready <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_dm  = dm_req & ~r_dm_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiters with LATENCY 0, 1 and 3 run side by side, each with its own
// inputs and its own memory model. The model drives valid read data only in
// the single cycle that is LATENCY cycles after mem_en and drives a poison
// value otherwise, so a capture in the wrong cycle returns the wrong data.
// Cycle n counts from the cycle in which the request is first driven (c0).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic [31:0] if_rdata  [N];
    logic        if_ready  [N];
    logic        dm_req    [N];
    logic        dm_we     [N];
    logic [31:0] dm_addr   [N];
    logic [31:0] dm_wdata  [N];
    logic [31:0] dm_rdata  [N];
    logic        dm_ready  [N];
    logic        stall_if  [N];
    logic        stall_dm  [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic [1:0]  dbg_state [N];

    int n_cmp  = 0;
    int n_fail = 0;

    // Results of the most recent run_one call.
    int          r_rdy_cyc;
    int          r_rdy_len;
    int          r_en_cnt;
    int          r_en_cyc;
    int          r_stall_cnt;
    int          r_other_rdy;
    logic [31:0] r_rdata;
    logic        r_we_en;
    logic [31:0] r_addr_en;
    logic [31:0] r_wdata_en;

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [4:0] age;

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .LATENCY(L), .STARVE_LIMIT(2)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_ready  (if_ready[g]),
            .dm_req    (dm_req[g]),
            .dm_we     (dm_we[g]),
            .dm_addr   (dm_addr[g]),
            .dm_wdata  (dm_wdata[g]),
            .dm_rdata  (dm_rdata[g]),
            .dm_ready  (dm_ready[g]),
            .stall_if  (stall_if[g]),
            .stall_dm  (stall_dm[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .dbg_state (dbg_state[g])
        );

        // Cycles since the last command strobe (0 in the strobe cycle itself).
        always @(posedge clk) begin
            if (reset) age <= 5'd31;
            else if (mem_en[g]) age <= 5'd1;
            else if (age != 5'd31) age <= age + 5'd1;
        end

        assign mem_rdata[g] = (((mem_en[g]) ? 5'd0 : age) == 5'(L)) ?
                              data_of(mem_addr[g]) : 32'hBAD0_BAD0;
    end

    task automatic idle_inputs();
        for (int k = 0; k < N; k++) begin
            if_req[k]   = 1'b0;
            if_addr[k]  = '0;
            dm_req[k]   = 1'b0;
            dm_we[k]    = 1'b0;
            dm_addr[k]  = '0;
            dm_wdata[k] = '0;
        end
    endtask

    // Driver: issues one request on instance k and records what happens.
    task automatic run_one(input int k, input bit is_dm, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        r_rdy_cyc = -1; r_rdy_len = 0; r_en_cnt = 0; r_en_cyc = -1;
        r_stall_cnt = 0; r_other_rdy = 0; r_rdata = '0;
        r_we_en = 1'b0; r_addr_en = '0; r_wdata_en = '0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (n == 0) begin
                if (is_dm) begin
                    dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
                end else begin
                    if_req[k] = 1'b1; if_addr[k] = addr;
                end
            end
            #1;
            if (mem_en[k]) begin
                r_en_cnt++;
                if (r_en_cyc < 0) begin
                    r_en_cyc = n; r_we_en = mem_we[k];
                    r_addr_en = mem_addr[k]; r_wdata_en = mem_wdata[k];
                end
            end
            if (is_dm ? stall_dm[k] : stall_if[k]) r_stall_cnt++;
            if (is_dm ? if_ready[k] : dm_ready[k]) r_other_rdy++;
            if (is_dm ? dm_ready[k] : if_ready[k]) begin
                r_rdy_len++;
                if (r_rdy_cyc < 0) begin
                    r_rdy_cyc = n;
                    r_rdata = is_dm ? dm_rdata[k] : if_rdata[k];
                end
                if (is_dm) dm_req[k] = 1'b0; else if_req[k] = 1'b0;
            end
        end
        if_req[k] = 1'b0;
        dm_req[k] = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({if_ready[k], dm_ready[k], mem_en[k], mem_we[k], stall_if[k], stall_dm[k]} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_flags k=%0d got %b want 000000", k,
                         {if_ready[k], dm_ready[k], mem_en[k], mem_we[k], stall_if[k], stall_dm[k]});
            end
            n_cmp++;
            if ({if_rdata[k], dm_rdata[k]} !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_rdata k=%0d got %h/%h want 0/0", k, if_rdata[k], dm_rdata[k]);
            end
            n_cmp++;
            if ({mem_addr[k], mem_wdata[k]} !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_mem k=%0d got %h/%h want 0/0", k, mem_addr[k], mem_wdata[k]);
            end
            n_cmp++;
            if (dbg_state[k] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got %0d want 0", k, dbg_state[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (mem_en[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_mem_en k=%0d got %b want 0", k, mem_en[k]);
            end
        end
    endtask

    task automatic test_if_fetch();
        for (int k = 0; k < N; k++) begin
            int L;
            L = lat_of(k);
            run_one(k, 1'b0, 1'b0, 32'h0040_0000, 32'h0);
            n_cmp++;
            if (r_rdy_cyc !== L + 2) begin
                n_fail++;
                $display("FAIL fetch_ready_cycle k=%0d got %0d want %0d", k, r_rdy_cyc, L + 2);
            end
            n_cmp++;
            if (r_rdata !== 32'h2008_0005) begin
                n_fail++;
                $display("FAIL fetch_rdata k=%0d got %h want 20080005", k, r_rdata);
            end
            n_cmp++;
            if (r_rdy_len !== 1) begin
                n_fail++;
                $display("FAIL fetch_ready_len k=%0d got %0d want 1", k, r_rdy_len);
            end
            n_cmp++;
            if (r_en_cyc !== 1 || r_en_cnt !== 1) begin
                n_fail++;
                $display("FAIL fetch_mem_en k=%0d got cyc %0d cnt %0d want cyc 1 cnt 1", k, r_en_cyc, r_en_cnt);
            end
            n_cmp++;
            if (r_we_en !== 1'b0 || r_addr_en !== 32'h0040_0000) begin
                n_fail++;
                $display("FAIL fetch_cmd k=%0d got we %b addr %h want we 0 addr 00400000", k, r_we_en, r_addr_en);
            end
            n_cmp++;
            if (r_stall_cnt !== L + 2) begin
                n_fail++;
                $display("FAIL fetch_stall_cycles k=%0d got %0d want %0d", k, r_stall_cnt, L + 2);
            end
            n_cmp++;
            if (r_other_rdy !== 0) begin
                n_fail++;
                $display("FAIL fetch_dm_ready k=%0d got %0d want 0", k, r_other_rdy);
            end
            n_cmp++;
            if (if_rdata[k] !== 32'h2008_0005) begin
                n_fail++;
                $display("FAIL fetch_rdata_hold k=%0d got %h want 20080005", k, if_rdata[k]);
            end
        end
    endtask

    task automatic test_load_store();
        for (int k = 0; k < N; k++) begin
            int L;
            L = lat_of(k);
            run_one(k, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
            n_cmp++;
            if (r_rdy_cyc !== L + 2 || r_rdata !== 32'h0008_FFF7) begin
                n_fail++;
                $display("FAIL load k=%0d got cyc %0d data %h want cyc %0d data 0008fff7", k, r_rdy_cyc, r_rdata, L + 2);
            end
            run_one(k, 1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
            n_cmp++;
            if (r_en_cnt !== 1 || r_en_cyc !== 1) begin
                n_fail++;
                $display("FAIL store_mem_en k=%0d got cyc %0d cnt %0d want cyc 1 cnt 1", k, r_en_cyc, r_en_cnt);
            end
            n_cmp++;
            if (r_we_en !== 1'b1 || r_addr_en !== 32'h1001_0004 || r_wdata_en !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL store_cmd k=%0d got we %b addr %h data %h want 1 10010004 deadbeef",
                         k, r_we_en, r_addr_en, r_wdata_en);
            end
            n_cmp++;
            if (r_rdy_cyc !== L + 2 || r_rdy_len !== 1) begin
                n_fail++;
                $display("FAIL store_ready k=%0d got cyc %0d len %0d want cyc %0d len 1", k, r_rdy_cyc, r_rdy_len, L + 2);
            end
            n_cmp++;
            if (r_rdata !== 32'h0008_FFF7 || dm_rdata[k] !== 32'h0008_FFF7) begin
                n_fail++;
                $display("FAIL store_rdata_hold k=%0d got %h/%h want 0008fff7", k, r_rdata, dm_rdata[k]);
            end
            n_cmp++;
            if (mem_we[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL store_we_idle k=%0d got %b want 0", k, mem_we[k]);
            end
        end
    endtask

    task automatic test_both();
        for (int k = 0; k < N; k++) begin
            int L, dm_cyc, if_cyc, dm_cnt, if_cnt;
            logic [31:0] dm_val, if_val;
            L = lat_of(k);
            dm_cyc = -1; if_cyc = -1; dm_cnt = 0; if_cnt = 0; dm_val = '0; if_val = '0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (n == 0) begin
                    if_req[k] = 1'b1; if_addr[k] = 32'h0040_0004;
                    dm_req[k] = 1'b1; dm_we[k] = 1'b0; dm_addr[k] = 32'h1001_0010;
                end
                #1;
                if (dm_ready[k]) begin
                    dm_cnt++;
                    if (dm_cyc < 0) begin dm_cyc = n; dm_val = dm_rdata[k]; end
                    dm_req[k] = 1'b0;
                end
                if (if_ready[k]) begin
                    if_cnt++;
                    if (if_cyc < 0) begin if_cyc = n; if_val = if_rdata[k]; end
                    if_req[k] = 1'b0;
                end
            end
            if_req[k] = 1'b0; dm_req[k] = 1'b0;
            n_cmp++;
            if (dm_cyc !== L + 2 || dm_val !== 32'h0010_FFEF) begin
                n_fail++;
                $display("FAIL both_dm_first k=%0d got cyc %0d data %h want cyc %0d data 0010ffef", k, dm_cyc, dm_val, L + 2);
            end
            n_cmp++;
            if (if_cyc !== 2 * L + 5 || if_val !== 32'h0004_FFFB) begin
                n_fail++;
                $display("FAIL both_if_second k=%0d got cyc %0d data %h want cyc %0d data 0004fffb", k, if_cyc, if_val, 2 * L + 5);
            end
            n_cmp++;
            if (dm_cnt !== 1 || if_cnt !== 1) begin
                n_fail++;
                $display("FAIL both_pulses k=%0d got dm %0d if %0d want 1 1", k, dm_cnt, if_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k < N; k++) begin
            int L, dm_cnt;
            L = lat_of(k);
            dm_cnt = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (n == 0) begin
                    dm_req[k] = 1'b1; dm_we[k] = 1'b0; dm_addr[k] = 32'h1001_0020;
                end
                if (n == 2) begin
                    reset = 1'b1; dm_req[k] = 1'b0;
                end
                if (n == 3) begin
                    #1;
                    n_cmp++;
                    if ({dm_ready[k], if_ready[k], mem_en[k], mem_we[k], stall_dm[k]} !== 5'b0) begin
                        n_fail++;
                        $display("FAIL midreset_flags k=%0d got %b want 00000", k,
                                 {dm_ready[k], if_ready[k], mem_en[k], mem_we[k], stall_dm[k]});
                    end
                    n_cmp++;
                    if ({dm_rdata[k], if_rdata[k], mem_addr[k], mem_wdata[k]} !== 128'h0) begin
                        n_fail++;
                        $display("FAIL midreset_data k=%0d got %h %h %h %h want 0", k,
                                 dm_rdata[k], if_rdata[k], mem_addr[k], mem_wdata[k]);
                    end
                    n_cmp++;
                    if (dbg_state[k] !== 2'd0) begin
                        n_fail++;
                        $display("FAIL midreset_state k=%0d got %0d want 0", k, dbg_state[k]);
                    end
                    reset = 1'b0;
                end
                if (n < 3) begin
                    #1;
                    if (dm_ready[k]) dm_cnt++;
                end
            end
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                #1;
                if (dm_ready[k]) dm_cnt++;
            end
            n_cmp++;
            if (dm_cnt !== 0) begin
                n_fail++;
                $display("FAIL midreset_no_ready k=%0d got %0d pulses want 0", k, dm_cnt);
            end
            run_one(k, 1'b0, 1'b0, 32'h0040_0000, 32'h0);
            n_cmp++;
            if (r_rdy_cyc !== L + 2 || r_rdata !== 32'h2008_0005) begin
                n_fail++;
                $display("FAIL midreset_recover k=%0d got cyc %0d data %h want cyc %0d data 20080005",
                         k, r_rdy_cyc, r_rdata, L + 2);
            end
        end
    endtask

    task automatic test_fair();
        int   got;
        int   stall_low;
        logic order[6];
        logic exp_order[6];
        int   exp_low;
`ifdef FAIR_ARB_EN
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_low   = 2;
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_low   = 0;
`endif
        got = 0; stall_low = 0;
        for (int i = 0; i < 6; i++) order[i] = 1'bx;
        for (int n = 0; n < 60 && got < 6; n++) begin
            @(negedge clk);
            if (n == 0) begin
                if_req[1] = 1'b1; if_addr[1] = 32'h0040_0000;
                dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h1001_0030;
            end
            #1;
            if (!stall_if[1]) stall_low++;
            if (dm_ready[1] || if_ready[1]) begin
                order[got] = dm_ready[1];
                got++;
            end
        end
        if_req[1] = 1'b0; dm_req[1] = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (got !== 6) begin
            n_fail++;
            $display("FAIL fair_grant_count got %0d want 6", got);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (order[i] !== exp_order[i]) begin
                n_fail++;
                $display("FAIL fair_order idx=%0d got dm=%b want dm=%b", i, order[i], exp_order[i]);
            end
        end
        n_cmp++;
        if (stall_low !== exp_low) begin
            n_fail++;
            $display("FAIL fair_stall_if_low got %0d cycles want %0d", stall_low, exp_low);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_if_fetch();
        test_load_store();
        test_both();
        test_reset_mid();
        test_fair();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
